frame_buffer_ctrl: RTL and testbench

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

---
 rtl/frame_buffer_ctrl.sv | 159 +++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer between file_register and a convolution engine: stores raw pixels, streams them out, collects results.
// Latency: first pixel offered 1 cycle after start; result read-back 1 cycle after i_get_pixels.
// Backpressure: o_conv_data is held while i_conv_ready=0; results accepted whenever i_res_valid=1 in PROCESS.
//
// Ports:
//   clock, reset                  - single clock, synchronous active-high reset
//   i_load, i_pixels              - pixel write strobe and data (raw frame)
//   i_start_conv                  - pulse that starts processing of the stored frame
//   i_get_pixels, o_pixels_to_reg - read strobe and returned processed pixel
//   o_frame_ready                 - a processed frame is available
//   o_conv_valid/_data, i_conv_ready - pixel stream towards the engine
//   i_res_valid, i_res_data       - result stream from the engine
//   o_overflow                    - sticky: a load was dropped with the buffer full
module frame_buffer_ctrl #(
  parameter int NB_DATA = 24,
  parameter int NB_ADDR = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_pixels,
  input  logic               i_start_conv,
  input  logic               i_get_pixels,
  output logic [NB_DATA-1:0] o_pixels_to_reg,
  output logic               o_frame_ready,
  output logic               o_conv_valid,
  output logic [NB_DATA-1:0] o_conv_data,
  input  logic               i_conv_ready,
  input  logic               i_res_valid,
  input  logic [NB_DATA-1:0] i_res_data,
  output logic               o_overflow
);

  localparam int DEPTH  = 2**NB_ADDR;
  // One extra bit so a completely full buffer (count == DEPTH) is representable.
  localparam int NB_CNT = NB_ADDR + 1;
  localparam logic [NB_CNT-1:0] C_DEPTH = NB_CNT'(DEPTH);
  localparam logic [NB_CNT-1:0] C_ONE   = NB_CNT'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PROCESS, ST_READY} state_t;

  state_t             r_state, w_state_nxt;
  logic [NB_CNT-1:0]  r_count, r_sent, r_res, r_get;
  logic [NB_CNT-1:0]  w_count_nxt, w_sent_nxt, w_res_nxt, w_get_nxt;
  logic [NB_DATA-1:0] r_in_mem  [DEPTH];
  logic [NB_DATA-1:0] r_out_mem [DEPTH];
  logic [NB_DATA-1:0] r_pix;
  logic               r_ovf;
  logic               w_in_we, w_out_we, w_ovf_set, w_pix_ld, w_conv_valid;
  logic [NB_ADDR-1:0] w_in_addr;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_sent_nxt   = r_sent;
    w_res_nxt    = r_res;
    w_get_nxt    = r_get;
    w_in_we      = 1'b0;
    w_in_addr    = r_count[NB_ADDR-1:0];
    w_out_we     = 1'b0;
    w_ovf_set    = 1'b0;
    w_pix_ld     = 1'b0;
    w_conv_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_load) begin
          if (r_count != C_DEPTH) begin
            w_in_we     = 1'b1;
            w_count_nxt = r_count + C_ONE;
          end else begin
            w_ovf_set = 1'b1;
          end
        end
        // Start looks at the post-load count so a same-cycle load is included.
        if (i_start_conv && (w_count_nxt != '0)) begin
          w_state_nxt = ST_PROCESS;
          w_sent_nxt  = '0;
          w_res_nxt   = '0;
          w_get_nxt   = '0;
        end
      end
      ST_PROCESS: begin
        w_conv_valid = (r_sent < r_count);
        if (w_conv_valid && i_conv_ready) begin
          w_sent_nxt = r_sent + C_ONE;
        end
        if (i_res_valid && (r_res < r_count)) begin
          w_out_we  = 1'b1;
          w_res_nxt = r_res + C_ONE;
          if (w_res_nxt == r_count) begin
            w_state_nxt = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (i_get_pixels) begin
          w_pix_ld  = 1'b1;
          w_get_nxt = (r_get == r_count - C_ONE) ? '0 : r_get + C_ONE;
        end
        // A load here begins a fresh frame at address 0.
        if (i_load) begin
          w_in_we     = 1'b1;
          w_in_addr   = '0;
          w_count_nxt = C_ONE;
          w_state_nxt = ST_IDLE;
        end
        // Count is never zero here, so a start always reprocesses.
        if (i_start_conv) begin
          w_state_nxt = ST_PROCESS;
          w_sent_nxt  = '0;
          w_res_nxt   = '0;
          w_get_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_sent  <= '0;
      r_res   <= '0;
      r_get   <= '0;
      r_pix   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_sent  <= w_sent_nxt;
      r_res   <= w_res_nxt;
      r_get   <= w_get_nxt;
      if (w_pix_ld) begin
        r_pix <= r_out_mem[r_get[NB_ADDR-1:0]];
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Buffer contents survive reset; writes are only suppressed while it is asserted.
  always_ff @(posedge clock) begin
    if (!reset && w_in_we) begin
      r_in_mem[w_in_addr] <= i_pixels;
    end
    if (!reset && w_out_we) begin
      r_out_mem[r_res[NB_ADDR-1:0]] <= i_res_data;
    end
  end

  assign o_conv_valid    = w_conv_valid;
  assign o_conv_data     = r_in_mem[r_sent[NB_ADDR-1:0]];
  assign o_frame_ready   = (r_state == ST_READY);
  assign o_pixels_to_reg = r_pix;
  assign o_overflow      = r_ovf;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl built with a 4-pixel buffer (NB_ADDR=2).
module tb_frame_buffer_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_load;
  logic [23:0] i_pixels;
  logic        i_start_conv;
  logic        i_get_pixels;
  logic [23:0] o_pixels_to_reg;
  logic        o_frame_ready;
  logic        o_conv_valid;
  logic [23:0] o_conv_data;
  logic        i_conv_ready;
  logic        i_res_valid;
  logic [23:0] i_res_data;
  logic        o_overflow;

  int total = 0;
  int bad   = 0;
  int nxfer;

  frame_buffer_ctrl #(.NB_DATA(24), .NB_ADDR(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_load         (i_load),
    .i_pixels       (i_pixels),
    .i_start_conv   (i_start_conv),
    .i_get_pixels   (i_get_pixels),
    .o_pixels_to_reg(o_pixels_to_reg),
    .o_frame_ready  (o_frame_ready),
    .o_conv_valid   (o_conv_valid),
    .o_conv_data    (o_conv_data),
    .i_conv_ready   (i_conv_ready),
    .i_res_valid    (i_res_valid),
    .i_res_data     (i_res_data),
    .o_overflow     (o_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [23:0] px);
    i_load   = 1'b1;
    i_pixels = px;
    tick();
    i_load   = 1'b0;
  endtask

  task automatic start();
    i_start_conv = 1'b1;
    tick();
    i_start_conv = 1'b0;
  endtask

  // Echo engine: always ready, returns each accepted pixel as its result in the same cycle.
  task automatic run_engine(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_frame_ready) break;
      i_conv_ready = 1'b1;
      i_res_valid  = o_conv_valid;
      i_res_data   = o_conv_data;
      if (o_conv_valid) n++;
      tick();
    end
    i_conv_ready = 1'b0;
    i_res_valid  = 1'b0;
  endtask

  task automatic get_chk(input string tag, input logic [23:0] exp);
    i_get_pixels = 1'b1;
    tick();
    i_get_pixels = 1'b0;
    chk(tag, 32'(o_pixels_to_reg), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; i_load = 1'b0; i_pixels = '0; i_start_conv = 1'b0;
    i_get_pixels = 1'b0; i_conv_ready = 1'b0; i_res_valid = 1'b0; i_res_data = '0;
    tick(); tick();
    chk("rst_ready", 32'(o_frame_ready), 0);
    chk("rst_valid", 32'(o_conv_valid), 0);
    chk("rst_ovf",   32'(o_overflow), 0);
    chk("rst_pix",   32'(o_pixels_to_reg), 0);
    reset = 1'b0;

    // Two-pixel frame, echo engine, read-back with wrap.
    load(24'h2AFF1D);
    load(24'h7FABFF);
    start();
    chk("a_valid", 32'(o_conv_valid), 1);
    chk("a_data0", 32'(o_conv_data), 32'h2AFF1D);
    run_engine(nxfer);
    chk("a_ready", 32'(o_frame_ready), 1);
    chk("a_xfers", 32'(nxfer), 2);
    chk("a_valid_off", 32'(o_conv_valid), 0);
    get_chk("a_get0", 24'h2AFF1D);
    get_chk("a_get1", 24'h7FABFF);
    get_chk("a_wrap", 24'h2AFF1D);
    tick();
    chk("a_hold", 32'(o_pixels_to_reg), 32'h2AFF1D);

    // Load while READY starts a one-pixel frame.
    load(24'h00FF00);
    chk("b_ready_clr", 32'(o_frame_ready), 0);
    chk("b_valid", 32'(o_conv_valid), 0);
    start();
    run_engine(nxfer);
    chk("b_ready", 32'(o_frame_ready), 1);
    chk("b_xfers", 32'(nxfer), 1);
    get_chk("b_get0", 24'h00FF00);
    get_chk("b_wrap", 24'h00FF00);

    // Start with an empty buffer is ignored.
    reset = 1'b1; tick(); reset = 1'b0;
    chk("c_rst_pix", 32'(o_pixels_to_reg), 0);
    start();
    chk("c_valid", 32'(o_conv_valid), 0);
    chk("c_ready", 32'(o_frame_ready), 0);
    tick();
    chk("c_valid2", 32'(o_conv_valid), 0);

    // Three-cycle stall on the engine side.
    load(24'h111111); load(24'h222222); load(24'h333333); load(24'h444444);
    chk("d_ovf", 32'(o_overflow), 0);
    start();
    chk("d_data0", 32'(o_conv_data), 32'h111111);
    i_conv_ready = 1'b1; i_res_valid = 1'b1; i_res_data = o_conv_data;
    tick();
    i_conv_ready = 1'b0; i_res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("d_stall_valid", 32'(o_conv_valid), 1);
      chk("d_stall_data", 32'(o_conv_data), 32'h222222);
      tick();
    end
    run_engine(nxfer);
    chk("d_ready", 32'(o_frame_ready), 1);
    chk("d_xfers", 32'(nxfer), 3);
    get_chk("d_get0", 24'h111111);
    get_chk("d_get1", 24'h222222);
    get_chk("d_get2", 24'h333333);
    get_chk("d_get3", 24'h444444);
    get_chk("d_wrap", 24'h111111);

    // Overflow: fifth load into a 4-deep buffer is dropped.
    load(24'hA00001); load(24'hA00002); load(24'hA00003); load(24'hA00004);
    chk("e_ovf_full", 32'(o_overflow), 0);
    load(24'hA00005);
    chk("e_ovf", 32'(o_overflow), 1);
    start();
    run_engine(nxfer);
    chk("e_xfers", 32'(nxfer), 4);
    chk("e_ready", 32'(o_frame_ready), 1);
    get_chk("e_get0", 24'hA00001);
    get_chk("e_get1", 24'hA00002);
    get_chk("e_get2", 24'hA00003);
    get_chk("e_get3", 24'hA00004);
    get_chk("e_wrap", 24'hA00001);
    chk("e_ovf_sticky", 32'(o_overflow), 1);

    // Reprocess from READY, then reset mid-frame; late results ignored.
    start();
    chk("f_ready_clr", 32'(o_frame_ready), 0);
    chk("f_valid", 32'(o_conv_valid), 1);
    i_conv_ready = 1'b1; i_res_valid = 1'b1; i_res_data = o_conv_data;
    tick();
    i_conv_ready = 1'b0; i_res_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("f_rst_valid", 32'(o_conv_valid), 0);
    chk("f_rst_ready", 32'(o_frame_ready), 0);
    chk("f_rst_ovf",   32'(o_overflow), 0);
    chk("f_rst_pix",   32'(o_pixels_to_reg), 0);
    i_res_valid = 1'b1; i_res_data = 24'hDEAD00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("f_late_ready", 32'(o_frame_ready), 0);
    end
    i_res_valid = 1'b0;

    // Load and start in the same cycle: processing includes the new pixel.
    i_load = 1'b1; i_pixels = 24'h5A5A5A; i_start_conv = 1'b1;
    tick();
    i_load = 1'b0; i_start_conv = 1'b0;
    chk("g_valid", 32'(o_conv_valid), 1);
    chk("g_data",  32'(o_conv_data), 32'h5A5A5A);
    run_engine(nxfer);
    chk("g_ready", 32'(o_frame_ready), 1);
    get_chk("g_get0", 24'h5A5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
